sync_fifo_param: RTL

Parametrised single-clock synchronous FIFO; next generation of the team's 16x8 FIFO.
- Adds: configurable width/depth, occupancy count, almost-full/almost-empty thresholds, defined simultaneous read/write at full and empty, sticky overflow/underflow error flags, read-data valid strobe.
- Sits between a producer and a consumer in the same clock domain.
- Replaces the fixed FIFO in new datapaths and in the existing FIFO testbench environment.

---
 rtl/sync_fifo_param.sv | 68 ++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with count, thresholds, sticky error flags; FIFO_FWFT_EN selects first-word fall-through
module sync_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [WIDTH-1:0]         din,
  input  logic                     read,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_MARGIN);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic rd_ok, wr_ok;
  assign full = count == FULL_C;
  assign empty = count == '0;
  assign almost_full = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);
  // storage is never cleared; writes in the reset cycle are dropped
  always_ff @(posedge clk)
    if (wr_ok & ~reset) mem[wptr] <= din;
  // pointers, occupancy and sticky error flags
  always_ff @(posedge clk)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr <= wr_ok ? wptr + 1'b1 : wptr;
      rptr <= rd_ok ? rptr + 1'b1 : rptr;
      count <= (wr_ok & ~rd_ok) ? count + 1'b1 : (rd_ok & ~wr_ok) ? count - 1'b1 : count;
      overflow <= overflow | (write & ~wr_ok);
      underflow <= underflow | (read & ~rd_ok);
    end
`ifdef FIFO_FWFT_EN
  assign dout = mem[rptr];
  assign dout_valid = ~empty;
`else
  // registered read port: data and strobe one cycle after an accepted read
  always_ff @(posedge clk)
    if (reset) begin
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok) dout <= mem[rptr];
    end
`endif
endmodule
